// File: rtl/rob_alloc_arbiter_pkg.sv
// rtl/rob_alloc_arbiter_pkg.sv - shared types for the ROB allocator arbiter
package rob_pkg;

  localparam int ROB_NUM_REQ  = 4;
  localparam int ROB_ID_WIDTH = 4;
  localparam int ROB_REQ_W    = $clog2(ROB_NUM_REQ);

  typedef enum logic {
    FREE_PRIO  = 1'b0,
    ALLOC_PRIO = 1'b1
  } arb_mode_e;

  typedef struct packed {
    logic [ROB_REQ_W-1:0]    req_idx;
    logic [ROB_ID_WIDTH-1:0] unique_id;
    logic [ROB_ID_WIDTH-1:0] orig_id;
  } out_stage_t;

endpackage

// File: rtl/rob_alloc_arbiter_rr_pick.sv
// rtl/rob_alloc_arbiter_rr_pick.sv - round-robin one-hot picker starting at ptr
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int REQ_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [REQ_W-1:0]   idx
);

  logic found;
  int   cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = REQ_W'(cand);
      end
    end
  end

endmodule

// File: rtl/rob_alloc_arbiter.sv
// rtl/rob_alloc_arbiter.sv - round-robin sharing of the ROB ID allocator between requesters and frees
// Optional counters enabled by defining ALLOC_ARB_STATS_EN.
module rob_alloc_arbiter
  import rob_pkg::*;
#(
  parameter int NUM_REQ        = ROB_NUM_REQ,
  parameter int ID_WIDTH       = ROB_ID_WIDTH,
  parameter int FREE_BURST_MAX = 4,
  localparam int REQ_W         = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][ID_WIDTH-1:0]  req_orig_id,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [REQ_W-1:0]                  out_req_idx,
  output logic [ID_WIDTH-1:0]               out_unique_id,
  output logic [ID_WIDTH-1:0]               out_orig_id,
  input  logic                              free_valid,
  input  logic [ID_WIDTH-1:0]               free_unique_id,
  output logic                              free_ready,
  output logic                              free_done_valid,
  output logic [ID_WIDTH-1:0]               free_done_orig_id,
  output logic                              alloc_req,
  output logic [ID_WIDTH-1:0]               alloc_orig_id,
  input  logic                              alloc_gnt,
  input  logic [ID_WIDTH-1:0]               alloc_unique_id,
  input  logic                              alloc_full,
  output logic                              al_free_req,
  output logic [ID_WIDTH-1:0]               al_free_unique_id,
  input  logic [ID_WIDTH-1:0]               al_restored_id
`ifdef ALLOC_ARB_STATS_EN
  ,
  output logic [15:0]                       stat_stall_cnt,
  output logic [NUM_REQ-1:0][15:0]          stat_grant_cnt
`endif
);

  localparam int BW = $clog2(FREE_BURST_MAX + 1);

  arb_mode_e            mode_q, mode_d;
  logic [BW-1:0]        burst_cnt_q, burst_cnt_d, burst_inc;
  logic [REQ_W-1:0]     rr_ptr_q;
  out_stage_t           out_q;
  logic                 out_valid_q;
  logic                 done_valid_q;
  logic [ID_WIDTH-1:0]  done_orig_q;

  logic                 free_issue, any_req, can_load, grant;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [REQ_W-1:0]     pick_idx;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign any_req   = |req_valid;
  assign can_load  = ~out_valid_q | out_ready;
  assign burst_inc = burst_cnt_q + BW'(1);

  // Frees win whenever the FSM allows; allocs fill the remaining slots.
  always_comb begin
    free_issue  = (mode_q == FREE_PRIO) && free_valid;
    alloc_req   = ~free_issue & can_load & any_req & ~alloc_full;
    grant       = alloc_req & alloc_gnt;
    req_ready   = grant ? pick_onehot : '0;
    mode_d      = mode_q;
    burst_cnt_d = burst_cnt_q;
    case (mode_q)
      FREE_PRIO: begin
        if (free_issue && any_req) begin
          if (burst_inc == BW'(FREE_BURST_MAX)) begin
            mode_d      = ALLOC_PRIO;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_inc;
          end
        end else begin
          burst_cnt_d = '0;
        end
      end
      ALLOC_PRIO: begin
        mode_d      = FREE_PRIO;
        burst_cnt_d = '0;
      end
      default: begin
        mode_d      = FREE_PRIO;
        burst_cnt_d = '0;
      end
    endcase
  end

  assign free_ready        = free_issue;
  assign al_free_req       = free_issue;
  assign al_free_unique_id = free_unique_id;
  assign alloc_orig_id     = req_orig_id[pick_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q       <= FREE_PRIO;
      burst_cnt_q  <= '0;
      rr_ptr_q     <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      done_valid_q <= 1'b0;
      done_orig_q  <= '0;
    end else begin
      mode_q       <= mode_d;
      burst_cnt_q  <= burst_cnt_d;
      done_valid_q <= free_issue;
      if (free_issue) begin
        done_orig_q <= al_restored_id;
      end
      if (grant) begin
        out_q.req_idx   <= pick_idx;
        out_q.unique_id <= alloc_unique_id;
        out_q.orig_id   <= alloc_orig_id;
        out_valid_q     <= 1'b1;
        rr_ptr_q        <= (pick_idx == REQ_W'(NUM_REQ - 1)) ? '0 : pick_idx + REQ_W'(1);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid         = out_valid_q;
  assign out_req_idx       = out_q.req_idx;
  assign out_unique_id     = out_q.unique_id;
  assign out_orig_id       = out_q.orig_id;
  assign free_done_valid   = done_valid_q;
  assign free_done_orig_id = done_orig_q;

`ifdef ALLOC_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_stall_cnt <= '0;
      stat_grant_cnt <= '0;
    end else begin
      if (any_req && !grant && stat_stall_cnt != 16'hFFFF) begin
        stat_stall_cnt <= stat_stall_cnt + 16'd1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant && pick_onehot[i] && stat_grant_cnt[i] != 16'hFFFF) begin
          stat_grant_cnt[i] <= stat_grant_cnt[i] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rob_alloc_arbiter.sv
// tb/tb_rob_alloc_arbiter.sv - directed self-checking bench for rob_alloc_arbiter
module tb_rob_alloc_arbiter;

  logic             clk;
  logic             rst;
  logic [3:0]       req_valid;
  logic [3:0][3:0]  req_orig_id;
  logic [3:0]       req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_req_idx;
  logic [3:0]       out_unique_id;
  logic [3:0]       out_orig_id;
  logic             free_valid;
  logic [3:0]       free_unique_id;
  logic             free_ready;
  logic             free_done_valid;
  logic [3:0]       free_done_orig_id;
  logic             alloc_req;
  logic [3:0]       alloc_orig_id;
  logic             alloc_gnt;
  logic [3:0]       alloc_unique_id;
  logic             alloc_full;
  logic             al_free_req;
  logic [3:0]       al_free_unique_id;
  logic [3:0]       al_restored_id;
`ifdef ALLOC_ARB_STATS_EN
  logic [15:0]      stat_stall_cnt;
  logic [3:0][15:0] stat_grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Allocator stand-in: always grants when not full; unique = orig+8, restore = bitwise invert.
  assign alloc_gnt       = alloc_req & ~alloc_full;
  assign alloc_unique_id = alloc_orig_id + 4'h8;
  assign al_restored_id  = ~al_free_unique_id;

  rob_alloc_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_orig_id       (req_orig_id),
    .req_ready         (req_ready),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_req_idx       (out_req_idx),
    .out_unique_id     (out_unique_id),
    .out_orig_id       (out_orig_id),
    .free_valid        (free_valid),
    .free_unique_id    (free_unique_id),
    .free_ready        (free_ready),
    .free_done_valid   (free_done_valid),
    .free_done_orig_id (free_done_orig_id),
    .alloc_req         (alloc_req),
    .alloc_orig_id     (alloc_orig_id),
    .alloc_gnt         (alloc_gnt),
    .alloc_unique_id   (alloc_unique_id),
    .alloc_full        (alloc_full),
    .al_free_req       (al_free_req),
    .al_free_unique_id (al_free_unique_id),
    .al_restored_id    (al_restored_id)
`ifdef ALLOC_ARB_STATS_EN
    ,
    .stat_stall_cnt    (stat_stall_cnt),
    .stat_grant_cnt    (stat_grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    req_valid      = '0;
    out_ready      = 1'b1;
    free_valid     = 1'b0;
    free_unique_id = '0;
    alloc_full     = 1'b0;
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = '0; out_ready = 1'b1; free_valid = 1'b0; free_unique_id = '0; alloc_full = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (free_done_valid !== 1'b0) begin errors++; $display("FAIL reset_done_valid got %b want 0", free_done_valid); end
    checks++; if ({out_req_idx, out_unique_id, out_orig_id} !== 10'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", {out_req_idx, out_unique_id, out_orig_id}); end
    checks++; if (free_done_orig_id !== 4'h0) begin errors++; $display("FAIL reset_done_id got %h want 0", free_done_orig_id); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = k % 4;
      #1;
      checks++; if (req_ready !== 4'(1 << exp)) begin errors++; $display("FAIL rr_req_ready[%0d] got %b want %b", k, req_ready, 4'(1 << exp)); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_req_idx !== 2'(exp)) begin errors++; $display("FAIL rr_out_idx[%0d] got v=%b idx=%0d want v=1 idx=%0d", k, out_valid, out_req_idx, exp); end
      checks++; if (out_orig_id !== 4'(exp + 1) || out_unique_id !== 4'(exp + 9)) begin errors++; $display("FAIL rr_out_ids[%0d] got %h/%h want %h/%h", k, out_orig_id, out_unique_id, 4'(exp + 1), 4'(exp + 9)); end
    end
    req_valid = '0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b want 0", out_valid); end
  endtask

  task automatic test_free_burst();
    do_reset();
    free_valid = 1'b1; free_unique_id = 4'h3; req_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (free_ready !== 1'b1 || al_free_req !== 1'b1 || alloc_req !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL burst_free[%0d] got fr=%b afr=%b ar=%b rr=%b want 1 1 0 0000", k, free_ready, al_free_req, alloc_req, req_ready); end
      tick();
    end
    #1;
    checks++; if (free_ready !== 1'b0 || alloc_req !== 1'b1 || req_ready !== 4'b0100) begin errors++; $display("FAIL burst_alloc got fr=%b ar=%b rr=%b want 0 1 0100", free_ready, alloc_req, req_ready); end
    tick();
    req_valid = '0;
    checks++; if (out_valid !== 1'b1 || out_req_idx !== 2'd2 || out_orig_id !== 4'h3) begin errors++; $display("FAIL burst_out got v=%b idx=%0d orig=%h want 1 2 3", out_valid, out_req_idx, out_orig_id); end
    #1;
    checks++; if (free_ready !== 1'b1 || alloc_req !== 1'b0) begin errors++; $display("FAIL burst_resume got fr=%b ar=%b want 1 0", free_ready, alloc_req); end
    free_valid = 1'b0;
    tick();
  endtask

  task automatic test_full();
    do_reset();
    alloc_full = 1'b1; req_valid = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (alloc_req !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL full_block[%0d] got ar=%b rr=%b want 0 0000", k, alloc_req, req_ready); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_no_out got %b want 0", out_valid); end
    alloc_full = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL full_release got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (out_valid !== 1'b1 || out_req_idx !== 2'd0) begin errors++; $display("FAIL full_out got v=%b idx=%0d want 1 0", out_valid, out_req_idx); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_first got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (alloc_req !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL bp_stall[%0d] got ar=%b rr=%b want 0 0000", k, alloc_req, req_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_req_idx !== 2'd1 || out_orig_id !== 4'h2 || out_unique_id !== 4'hA) begin errors++; $display("FAIL bp_hold[%0d] got v=%b idx=%0d %h/%h want 1 1 2/a", k, out_valid, out_req_idx, out_orig_id, out_unique_id); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_drain_grant got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (out_valid !== 1'b1 || out_req_idx !== 2'd0 || out_orig_id !== 4'h1) begin errors++; $display("FAIL bp_reload got v=%b idx=%0d orig=%h want 1 0 1", out_valid, out_req_idx, out_orig_id); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_free_return();
    do_reset();
    req_valid = 4'b0001; free_valid = 1'b1; free_unique_id = 4'h5;
    #1;
    checks++; if (alloc_req !== 1'b0 || free_ready !== 1'b1 || al_free_unique_id !== 4'h5) begin errors++; $display("FAIL fr_issue got ar=%b fr=%b id=%h want 0 1 5", alloc_req, free_ready, al_free_unique_id); end
    tick();
    free_valid = 1'b0; req_valid = '0;
    checks++; if (free_done_valid !== 1'b1 || free_done_orig_id !== 4'hA) begin errors++; $display("FAIL fr_done got v=%b id=%h want 1 a", free_done_valid, free_done_orig_id); end
    tick();
    checks++; if (free_done_valid !== 1'b0) begin errors++; $display("FAIL fr_pulse got %b want 0", free_done_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0; req_valid = 4'b0001;
    tick();
    req_valid = '0; free_valid = 1'b1; free_unique_id = 4'h6;
    tick();
    free_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || free_done_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got ov=%b dv=%b want 1 1", out_valid, free_done_valid); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || free_done_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got ov=%b dv=%b want 0 0", out_valid, free_done_valid); end
    checks++; if ({out_req_idx, out_unique_id, out_orig_id, free_done_orig_id} !== 14'h0) begin errors++; $display("FAIL mid_async_data got %h want 0", {out_req_idx, out_unique_id, out_orig_id, free_done_orig_id}); end
    #1;
    rst = 1'b1;
    tick();
    out_ready = 1'b1; req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (out_req_idx !== 2'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_out got v=%b idx=%0d want 1 0", out_valid, out_req_idx); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) req_orig_id[i] = 4'(i + 1);
    test_reset();
    test_round_robin();
    test_free_burst();
    test_full();
    test_backpressure();
    test_free_return();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
